res_mem_arbiter: RTL and testbench

- Shares the single-port 128x128x8 result RAM (res_* interface) among three requesters: forward-pass engine, backward-pass engine and host readout/dump port.
- Grants are round-robin with burst locking. The winning requester's transactions are registered onto the RAM pins, and read data is routed back with a per-requester valid tag.
- Sits between the distance-transform engines and the result RAM, replacing direct res_* drive from any single engine.

---
 rtl/dt_pkg.sv | 21 ++
 rtl/res_mem_arbiter_if.sv | 26 ++
 rtl/res_mem_arbiter_rr_pick.sv | 35 +++
 rtl/res_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_res_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dt_pkg.sv
// Shared constants and types for the distance-transform blocks and their
// result-RAM arbiter.
package dt_pkg;

  localparam int unsigned RES_ADDR_W = 14;
  localparam int unsigned RES_DATA_W = 8;
  localparam int unsigned NREQ       = 3;

  localparam int unsigned REQ_FWD    = 0;
  localparam int unsigned REQ_BWD    = 1;
  localparam int unsigned REQ_HOST   = 2;

  localparam int unsigned STI_ADDR_W = 10;
  localparam int unsigned IMG_DIM    = 128;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

endpackage

// File: rtl/res_mem_arbiter_if.sv
// Requester-side bus of the result-RAM arbiter: packed per-requester
// request fields plus grant and tagged read-return.
interface res_mem_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/res_mem_arbiter_rr_pick.sv
// Combinational one-hot round-robin selector: first (req & mask) bit at or
// after ptr, wrapping cyclically.
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             found
);
  logic [N-1:0] cand;

  assign cand = req & mask;

  // Two constant-index passes (upper segment, then wrapped lower segment)
  // instead of a variable rotate.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && cand[j] && (j >= 32'(ptr))) begin
        onehot[j] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && cand[j]) begin
        onehot[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/res_mem_arbiter.sv
// Round-robin, burst-locking arbiter sharing the single-port result RAM
// between the forward, backward and host requesters.
module res_mem_arbiter #(
  parameter int unsigned NREQ     = dt_pkg::NREQ,
  parameter int unsigned ADDR_W   = dt_pkg::RES_ADDR_W,
  parameter int unsigned DATA_W   = dt_pkg::RES_DATA_W,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              reset,
  res_mem_arbiter_if.slave  bus,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);
  import dt_pkg::*;

  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;

  logic              accept, forced, release_grant;
  logic              owner_we, owner_lock;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;
  logic [PTR_W-1:0]  owner_next;

  logic [NREQ-1:0]   pick_mask, pick_onehot;
  logic [PTR_W-1:0]  pick_ptr;
  logic              pick_found;

  logic [NREQ-1:0]   tag1_q, tag2_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // Owner's request fields muxed by the one-hot grant.
  always_comb begin
    owner_we    = 1'b0;
    owner_lock  = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    owner_next  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        owner_we    = bus.we[i];
        owner_lock  = bus.lock[i];
        owner_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        owner_wdata = bus.wdata[i*DATA_W +: DATA_W];
        owner_next  = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign accept        = |(gnt_q & bus.req);
  assign hold_inc      = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
  assign forced        = (MAX_HOLD != 0) && accept && (hold_inc == HOLD_LAST);
  assign release_grant = !owner_lock || forced;

  assign pick_mask = (state_q == ARB_OWNED) ? ~gnt_q : '1;
  assign pick_ptr  = (state_q == ARB_OWNED) ? owner_next : rr_ptr_q;

  rr_pick #(.N(NREQ), .PTR_W(PTR_W)) u_pick (
    .req    (bus.req),
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .found  (pick_found)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_OWNED;
          gnt_d   = pick_onehot;
        end
      end
      ARB_OWNED: begin
        if (accept) hold_cnt_d = hold_inc;
        // Handover goes straight to the next requester when one is waiting.
        if (release_grant) begin
          rr_ptr_d   = owner_next;
          hold_cnt_d = '0;
          gnt_d      = pick_onehot;
          state_d    = pick_found ? ARB_OWNED : ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Read tags ride alongside the RAM access so data returns to the
  // requester that issued it, whatever the grant does meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      res_rd <= accept && !owner_we;
      res_wr <= accept && owner_we;
      if (accept) begin
        res_addr <= owner_addr;
        res_do   <= owner_wdata;
      end
      tag1_q   <= (accept && !owner_we) ? gnt_q : '0;
      tag2_q   <= tag1_q;
      rvalid_q <= tag2_q;
      if (|tag2_q) rdata_q <= res_di;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_res_mem_arbiter.sv
// Bench for res_mem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level arbitration model and a shadow memory.
module tb_res_mem_arbiter;
  import dt_pkg::*;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do;
  logic [DW-1:0] res_di = '0;

  res_mem_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  res_mem_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .res_rd   (res_rd),
    .res_wr   (res_wr),
    .res_addr (res_addr),
    .res_do   (res_do),
    .res_di   (res_di)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(logic [13:0] a);
    if (a == 14'h0081) return 8'd5;
    return a[7:0] ^ {1'b0, a[13:7]} ^ 8'hA5;
  endfunction

  // RAM: registered read, contents default to init_val until written.
  logic [7:0] ram      [0:16383];
  logic       ram_seen [0:16383];
  always @(posedge clk) begin
    if (res_wr) begin
      ram[res_addr]      <= res_do;
      ram_seen[res_addr] <= 1'b1;
    end
    if (res_rd) res_di <= ram_seen[res_addr] ? ram[res_addr] : init_val(res_addr);
  end

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct {
    int         due;
    int         owner;
    logic [7:0] data;
  } ret_t;

  txn_t       tq [N][$];
  ret_t       ret_q [$];
  logic [7:0] ref_mem [0:16383];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         rv0_cnt  = 0;
  int         m_own    = -1;
  int         m_ptr    = 0;
  int         m_cnt    = 0;
  logic       e_rd, e_wr;
  logic [13:0] e_addr;
  logic [7:0] e_do;
  logic [2:0] lock_cfg = '0;
  logic       lock_auto = 1'b1;
  logic       rst_drv = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic bit_of(logic [2:0] v, int j);
    logic [2:0] s;
    s = v >> j;
    return s[0];
  endfunction

  function automatic txn_t mk(logic we, logic [13:0] a, logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // First requester at or after start (cyclic) with req high, skipping excl.
  function automatic int pick(logic [2:0] r, int start, int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (bit_of(r, j) && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic run_cycle();
    logic [2:0]  rq, lk, wev, acc, exp_gnt;
    logic [41:0] av;
    logic [23:0] dv;
    txn_t        t;
    ret_t        rr;
    int          i;
    rq = '0; lk = '0; wev = '0; acc = '0; av = '0; dv = '0;
    for (int r = 0; r < N; r++) begin
      if (tq[r].size() > 0) begin
        t   = tq[r][0];
        rq  = rq | (3'b001 << r);
        wev = wev | (3'(t.we) << r);
        av  = av | (42'(t.addr) << (r * AW));
        dv  = dv | (24'(t.wdata) << (r * DW));
      end
      if (bit_of(lock_cfg, r) && (!lock_auto || tq[r].size() > 1)) lk = lk | (3'b001 << r);
    end
    bus.req = rq; bus.lock = lk; bus.we = wev; bus.addr = av; bus.wdata = dv;
    reset = rst_drv;

    e_rd = 1'b0; e_wr = 1'b0;
    if (rst_drv) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
      ret_q.delete();
      e_addr = '0; e_do = '0;
    end else if (m_own < 0) begin
      m_own = pick(rq, m_ptr, -1);
    end else begin
      i = m_own;
      if (bit_of(rq, i)) begin
        t = tq[i][0];
        acc = 3'b001 << i;
        e_rd = !t.we; e_wr = t.we; e_addr = t.addr; e_do = t.wdata;
        if (t.we) ref_mem[t.addr] = t.wdata;
        else ret_q.push_back('{due: cyc + 3, owner: i, data: ref_mem[t.addr]});
        m_cnt++;
      end
      if (!bit_of(lk, i) || (MH != 0 && acc != '0 && m_cnt == MH)) begin
        m_ptr = (i + 1) % N;
        m_cnt = 0;
        m_own = pick(rq, m_ptr, i);
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < N; r++) if (bit_of(acc, r)) void'(tq[r].pop_front());

    exp_gnt = (m_own < 0) ? 3'b000 : (3'b001 << m_own);
    check("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("res_rd", 32'(res_rd), 32'(e_rd));
    check("res_wr", 32'(res_wr), 32'(e_wr));
    if (e_rd || e_wr) check("res_addr", 32'(res_addr), 32'(e_addr));
    if (e_wr) check("res_do", 32'(res_do), 32'(e_do));
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      rr = ret_q.pop_front();
      check("rvalid", 32'(bus.rvalid), 32'(3'b001 << rr.owner));
      check("rdata", 32'(bus.rdata), 32'(rr.data));
    end else begin
      check("rvalid", 32'(bus.rvalid), 32'd0);
    end
    if (bus.rvalid[0]) rv0_cnt++;
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    run_cycle();
    run_cycle();
    rst_drv = 1'b0;
  endtask

  task automatic clear_queues();
    for (int r = 0; r < N; r++) tq[r].delete();
  endtask

  task automatic rand_fill();
    for (int r = 0; r < N; r++) begin
      if (tq[r].size() < 2 && $urandom_range(0, 99) < 35) begin
        tq[r].push_back(mk(1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15)),
                           8'($urandom)));
      end
    end
    lock_cfg = '0;
    for (int r = 0; r < N; r++) if ($urandom_range(0, 99) < 30) lock_cfg = lock_cfg | (3'b001 << r);
    rst_drv = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) ref_mem[a] = init_val(14'(a));

    // Reset state
    do_reset();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_res_rd", 32'(res_rd), 32'd0);
    check("rst_res_wr", 32'(res_wr), 32'd0);
    check("rst_res_addr", 32'(res_addr), 32'd0);
    check("rst_res_do", 32'(res_do), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);

    // Single read of 0x0081 (holds 5)
    lock_cfg = '0; lock_auto = 1'b1;
    tq[0].push_back(mk(1'b0, 14'h0081, 8'h00));
    run_cycle(); check("sr_gnt", 32'(bus.gnt), 32'h1);
    run_cycle(); check("sr_res_rd", 32'(res_rd), 32'h1);
    check("sr_res_addr", 32'(res_addr), 32'h81);
    check("sr_gnt_rel", 32'(bus.gnt), 32'h0);
    run_cycle(); run_cycle();
    check("sr_rvalid", 32'(bus.rvalid), 32'h1);
    check("sr_rdata", 32'(bus.rdata), 32'h5);

    // Contention from IDLE with rr_ptr at 0
    do_reset();
    for (int r = 0; r < N; r++) tq[r].push_back(mk(1'b0, 14'(r + 32), 8'h00));
    run_cycle(); check("ct_gnt0", 32'(bus.gnt), 32'h1);
    run_cycle(); check("ct_gnt1", 32'(bus.gnt), 32'h2);
    run_cycle(); check("ct_gnt2", 32'(bus.gnt), 32'h4);
    run_cycle(); check("ct_idle", 32'(bus.gnt), 32'h0);
    repeat (3) run_cycle();

    // Forced release after MAX_HOLD accepted reads
    do_reset();
    lock_cfg = 3'b001; lock_auto = 1'b0; rv0_cnt = 0;
    for (int k = 0; k < 4; k++) tq[0].push_back(mk(1'b0, 14'(16'h0200 + k), 8'h00));
    tq[1].push_back(mk(1'b0, 14'h0300, 8'h00));
    run_cycle(); check("fr_gnt", 32'(bus.gnt), 32'h1);
    for (int k = 0; k < 3; k++) begin
      run_cycle(); check("fr_hold", 32'(bus.gnt), 32'h1);
    end
    run_cycle(); check("fr_handover", 32'(bus.gnt), 32'h2);
    lock_cfg = '0; lock_auto = 1'b1;
    repeat (6) run_cycle();
    check("fr_rvalid0_cnt", 32'(rv0_cnt), 32'd4);

    // Reset one cycle after a read is accepted
    do_reset();
    lock_cfg = 3'b001;
    for (int k = 0; k < 4; k++) tq[0].push_back(mk(1'b0, 14'(16'h0400 + k), 8'h00));
    tq[2].push_back(mk(1'b0, 14'h0500, 8'h00));
    run_cycle(); check("mr_gnt", 32'(bus.gnt), 32'h1);
    run_cycle(); check("mr_res_rd", 32'(res_rd), 32'h1);
    rst_drv = 1'b1;
    run_cycle();
    check("mr_gnt_rst", 32'(bus.gnt), 32'h0);
    check("mr_res_rd_rst", 32'(res_rd), 32'h0);
    check("mr_rvalid_rst", 32'(bus.rvalid), 32'h0);
    rst_drv = 1'b0;
    run_cycle();
    check("mr_gnt_low", 32'(bus.gnt), 32'h1);
    check("mr_rvalid_gone", 32'(bus.rvalid), 32'h0);
    lock_cfg = '0;
    repeat (12) run_cycle();
    clear_queues();

    // Write then read of the same location by the host
    do_reset();
    lock_cfg = 3'b100; lock_auto = 1'b1;
    tq[2].push_back(mk(1'b1, 14'h0102, 8'h2A));
    tq[2].push_back(mk(1'b0, 14'h0102, 8'h00));
    run_cycle(); check("wr_gnt", 32'(bus.gnt), 32'h4);
    run_cycle(); check("wr_res_wr", 32'(res_wr), 32'h1);
    check("wr_res_addr", 32'(res_addr), 32'h102);
    check("wr_res_do", 32'(res_do), 32'h2A);
    run_cycle(); check("wr_res_rd", 32'(res_rd), 32'h1);
    check("wr_res_wr_low", 32'(res_wr), 32'h0);
    run_cycle(); run_cycle();
    check("wr_rvalid", 32'(bus.rvalid), 32'h4);
    check("wr_rdata", 32'(bus.rdata), 32'h2A);

    // Random traffic
    lock_auto = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_fill();
      run_cycle();
    end
    rst_drv = 1'b0; lock_cfg = '0;
    repeat (40) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
